// File: rtl/hdpldadapt_rx_datapath_fifo_rd_ctl.sv
// RX datapath FIFO read-side controller: registered flags, start-up fill
// FSM, read enable, underflow status and occupancy high-water mark.
module hdpldadapt_rx_datapath_fifo_rd_ctl #(
  parameter int AWIDTH   = 4,
  parameter int DEPTH    = 16,
  parameter int PS_DEPTH = 8
) (
  input  logic              rd_clk,
  input  logic              rd_srst,
  input  logic [AWIDTH-1:0] rd_numdata,
  input  logic              rd_req,
  input  logic [2:0]        r_fifo_power_mode,
  input  logic              r_double_read,
  input  logic              r_stop_read,
  input  logic [AWIDTH-1:0] r_empty_thresh,
  input  logic [AWIDTH-1:0] r_pempty_thresh,
  input  logic [AWIDTH-1:0] r_pfull_thresh,
  input  logic [AWIDTH-1:0] r_start_level,
  input  logic              r_auto_restart,
  input  logic              status_clr,
  output logic              rd_en,
  output logic              rd_empty,
  output logic              rd_pempty,
  output logic              rd_pfull,
  output logic              rd_underflow,
  output logic              rd_underflow_sticky,
  output logic [AWIDTH-1:0] rd_numdata_max,
  output logic [1:0]        rd_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    READ = 2'd2
  } state_t;

  localparam logic [AWIDTH-1:0] PS_MAX  = AWIDTH'(PS_DEPTH - 1);
  localparam logic [AWIDTH-1:0] PS2_MAX = AWIDTH'(2 * PS_DEPTH - 1);
  localparam logic [AWIDTH-1:0] FL_MAX  = AWIDTH'(DEPTH - 1);
  localparam logic [AWIDTH-1:0] TWO     = AWIDTH'(2);

  function automatic logic [AWIDTH-1:0] clamp(
    input logic [AWIDTH-1:0] t,
    input logic [AWIDTH-1:0] m
  );
    return (t > m) ? m : t;
  endfunction

  state_t            state, state_nxt;
  logic [AWIDTH-1:0] numdata_q;
  logic [AWIDTH-1:0] emax;
  logic [AWIDTH-1:0] empty_eff, pempty_eff, pfull_eff, start_eff;
  logic              uf_cond;

  always_comb begin
    emax = FL_MAX;
    if (!r_fifo_power_mode[1])      emax = PS_MAX;
    else if (!r_fifo_power_mode[2]) emax = PS2_MAX;
  end

  assign empty_eff  = clamp(r_empty_thresh, emax);
  assign pempty_eff = clamp(r_pempty_thresh, emax);
  assign pfull_eff  = clamp(r_pfull_thresh, emax);
  assign start_eff  = clamp(r_start_level, emax);

  // Underflow is judged on the registered empty flag, independent of stop_read.
  assign uf_cond = (state == READ) & rd_req & rd_empty;

  // Only registered terms here: no path from rd_numdata back to the pointers.
  assign rd_en    = (state == READ) & rd_req & ~(r_stop_read & rd_empty);
  assign rd_state = state;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = FILL;
      FILL:    if (numdata_q >= start_eff) state_nxt = READ;
      READ:    if (uf_cond && r_auto_restart) state_nxt = FILL;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_srst) begin
      state               <= IDLE;
      numdata_q           <= '0;
      rd_empty            <= 1'b1;
      rd_pempty           <= 1'b1;
      rd_pfull            <= 1'b0;
      rd_underflow        <= 1'b0;
      rd_underflow_sticky <= 1'b0;
      rd_numdata_max      <= '0;
    end else begin
      state        <= state_nxt;
      numdata_q    <= rd_numdata;
      rd_empty     <= (numdata_q <= empty_eff) |
                      (r_double_read & (numdata_q < TWO));
      rd_pempty    <= numdata_q <= pempty_eff;
      rd_pfull     <= numdata_q >= pfull_eff;
      rd_underflow <= uf_cond;
      rd_underflow_sticky <= uf_cond | (rd_underflow_sticky & ~status_clr);
      if (status_clr || numdata_q > rd_numdata_max)
        rd_numdata_max <= numdata_q;
    end
  end

endmodule

// File: tb/tb_hdpldadapt_rx_datapath_fifo_rd_ctl.sv
// Self-checking bench for the RX FIFO read controller: directed scenarios
// plus randomized traffic against a cycle-level reference model.
module tb_hdpldadapt_rx_datapath_fifo_rd_ctl;

  logic       clk = 1'b0;
  logic       rd_srst;
  logic [3:0] rd_numdata;
  logic       rd_req;
  logic [2:0] r_fifo_power_mode;
  logic       r_double_read, r_stop_read, r_auto_restart, status_clr;
  logic [3:0] r_empty_thresh, r_pempty_thresh, r_pfull_thresh, r_start_level;
  logic       rd_en, rd_empty, rd_pempty, rd_pfull;
  logic       rd_underflow, rd_underflow_sticky;
  logic [3:0] rd_numdata_max;
  logic [1:0] rd_state;

  int checks = 0;
  int failures = 0;

  // Reference model state (values visible after the most recent edge)
  int m_state, m_q, m_max;
  bit m_empty, m_pempty, m_pfull, m_uf, m_sticky;

  logic [11:0] act;
  assign act = {rd_en, rd_empty, rd_pempty, rd_pfull, rd_underflow,
                rd_underflow_sticky, rd_numdata_max, rd_state};

  hdpldadapt_rx_datapath_fifo_rd_ctl #(
    .AWIDTH(4), .DEPTH(16), .PS_DEPTH(8)
  ) dut (
    .rd_clk(clk), .rd_srst(rd_srst), .rd_numdata(rd_numdata),
    .rd_req(rd_req), .r_fifo_power_mode(r_fifo_power_mode),
    .r_double_read(r_double_read), .r_stop_read(r_stop_read),
    .r_empty_thresh(r_empty_thresh), .r_pempty_thresh(r_pempty_thresh),
    .r_pfull_thresh(r_pfull_thresh), .r_start_level(r_start_level),
    .r_auto_restart(r_auto_restart), .status_clr(status_clr),
    .rd_en(rd_en), .rd_empty(rd_empty), .rd_pempty(rd_pempty),
    .rd_pfull(rd_pfull), .rd_underflow(rd_underflow),
    .rd_underflow_sticky(rd_underflow_sticky),
    .rd_numdata_max(rd_numdata_max), .rd_state(rd_state)
  );

  always #5 clk = ~clk;

  function automatic int depth_max(input logic [2:0] m);
    if (!m[1]) return 7;
    if (!m[2]) return 15;
    return 15;
  endfunction

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [11:0] exp_vec();
    logic en;
    en = (m_state == 2) && rd_req && !(r_stop_read && m_empty);
    return {en, m_empty, m_pempty, m_pfull, m_uf, m_sticky,
            4'(m_max), 2'(m_state)};
  endfunction

  // One rd_clk edge; the model advances from the inputs seen at that edge.
  task automatic tick();
    bit rst, req, dbl, ar, clr, uf;
    int nd, e, ns;
    logic [2:0] md;
    int et, pt, ft, st;
    rst = rd_srst; req = rd_req; dbl = r_double_read;
    ar = r_auto_restart; clr = status_clr; nd = rd_numdata;
    md = r_fifo_power_mode;
    et = r_empty_thresh; pt = r_pempty_thresh;
    ft = r_pfull_thresh; st = r_start_level;
    @(posedge clk);
    #1;
    if (rst) begin
      m_state = 0; m_q = 0; m_max = 0;
      m_empty = 1; m_pempty = 1; m_pfull = 0; m_uf = 0; m_sticky = 0;
    end else begin
      e  = depth_max(md);
      uf = (m_state == 2) && req && m_empty;
      ns = m_state;
      if (m_state == 0) ns = 1;
      else if (m_state == 1 && m_q >= mn(st, e)) ns = 2;
      else if (m_state == 2 && uf && ar) ns = 1;
      m_state  = ns;
      m_empty  = (m_q <= mn(et, e)) || (dbl && m_q < 2);
      m_pempty = m_q <= mn(pt, e);
      m_pfull  = m_q >= mn(ft, e);
      m_uf     = uf;
      m_sticky = uf || (m_sticky && !clr);
      m_max    = clr ? m_q : (m_q > m_max ? m_q : m_max);
      m_q      = nd;
    end
  endtask

  task automatic test_reset();
    rd_srst = 1; rd_req = 1; rd_numdata = 4'd9;
    tick(); tick();
    checks++;
    if (act !== 12'b0_1_1_0_0_0_0000_00) begin
      failures++;
      $display("FAIL reset_vals: got %b want %b", act, 12'b011000000000);
    end
    checks++;
    if (act !== exp_vec()) begin
      failures++;
      $display("FAIL reset_model: got %b want %b", act, exp_vec());
    end
    rd_numdata = 0;
    rd_srst = 0;
  endtask

  task automatic test_fill();
    tick();
    checks++;
    if (rd_state !== 2'd1 || rd_en !== 1'b0) begin
      failures++;
      $display("FAIL fill_enter: state %0d en %b want 1 0", rd_state, rd_en);
    end
    for (int i = 0; i <= 6; i++) begin
      rd_numdata = 4'(i);
      tick();
      checks++;
      if (rd_state !== ((i >= 5) ? 2'd2 : 2'd1) ||
          rd_en !== (i >= 5)) begin
        failures++;
        $display("FAIL fill_ramp[%0d]: state %0d en %b", i, rd_state, rd_en);
      end
      checks++;
      if (act !== exp_vec()) begin
        failures++;
        $display("FAIL fill_model[%0d]: got %b want %b", i, act, exp_vec());
      end
    end
  endtask

  task automatic test_pfull_clamp();
    r_fifo_power_mode = 3'b000; r_pfull_thresh = 4'd12; rd_numdata = 4'd7;
    tick(); tick(); tick();
    checks++;
    if (rd_pfull !== 1'b1) begin
      failures++;
      $display("FAIL pfull_clamp: got %b want 1", rd_pfull);
    end
    r_fifo_power_mode = 3'b110;
    tick();
    checks++;
    if (rd_pfull !== 1'b0) begin
      failures++;
      $display("FAIL pfull_full_depth: got %b want 0", rd_pfull);
    end
    checks++;
    if (act !== exp_vec()) begin
      failures++;
      $display("FAIL pfull_model: got %b want %b", act, exp_vec());
    end
  endtask

  task automatic test_underflow_restart();
    int pulses = 0;
    r_stop_read = 1; r_auto_restart = 1; r_empty_thresh = 0;
    rd_numdata = 0; rd_req = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rd_underflow) pulses++;
      checks++;
      if (act !== exp_vec()) begin
        failures++;
        $display("FAIL uf_restart_model[%0d]: got %b want %b",
                 i, act, exp_vec());
      end
      checks++;
      if (rd_empty && rd_en !== 1'b0) begin
        failures++;
        $display("FAIL uf_restart_gate[%0d]: en %b want 0", i, rd_en);
      end
    end
    checks++;
    if (pulses !== 1 || rd_state !== 2'd1) begin
      failures++;
      $display("FAIL uf_restart: pulses %0d state %0d want 1 1",
               pulses, rd_state);
    end
  endtask

  task automatic test_underflow_stay();
    int pulses = 0;
    r_stop_read = 0; r_auto_restart = 0; rd_numdata = 4'd5;
    tick(); tick(); tick();
    rd_numdata = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rd_underflow) pulses++;
      checks++;
      if (rd_en !== 1'b1 || rd_state !== 2'd2) begin
        failures++;
        $display("FAIL uf_stay[%0d]: en %b state %0d want 1 2",
                 i, rd_en, rd_state);
      end
    end
    checks++;
    if (pulses < 1 || rd_underflow_sticky !== 1'b1) begin
      failures++;
      $display("FAIL uf_stay_pulse: pulses %0d sticky %b",
               pulses, rd_underflow_sticky);
    end
    status_clr = 1;
    tick();
    checks++;
    if (rd_underflow_sticky !== 1'b1) begin
      failures++;
      $display("FAIL sticky_set_wins: got %b want 1", rd_underflow_sticky);
    end
    rd_req = 0;
    tick();
    status_clr = 0;
    checks++;
    if (rd_underflow_sticky !== 1'b0) begin
      failures++;
      $display("FAIL sticky_clear: got %b want 0", rd_underflow_sticky);
    end
    checks++;
    if (act !== exp_vec()) begin
      failures++;
      $display("FAIL uf_stay_model: got %b want %b", act, exp_vec());
    end
  endtask

  task automatic test_double_read();
    r_double_read = 1; r_empty_thresh = 0; rd_numdata = 4'd1;
    tick(); tick();
    checks++;
    if (rd_empty !== 1'b1) begin
      failures++;
      $display("FAIL dbl_one: got %b want 1", rd_empty);
    end
    rd_numdata = 4'd2;
    tick(); tick();
    checks++;
    if (rd_empty !== 1'b0) begin
      failures++;
      $display("FAIL dbl_two: got %b want 0", rd_empty);
    end
    r_double_read = 0;
  endtask

  task automatic test_hwm_reset();
    status_clr = 1; rd_numdata = 0;
    tick(); tick();
    status_clr = 0; rd_numdata = 4'd9;
    tick(); tick();
    rd_numdata = 4'd3;
    tick(); tick();
    checks++;
    if (rd_numdata_max !== 4'd9) begin
      failures++;
      $display("FAIL hwm_peak: got %0d want 9", rd_numdata_max);
    end
    status_clr = 1;
    tick();
    status_clr = 0;
    checks++;
    if (rd_numdata_max !== 4'd3) begin
      failures++;
      $display("FAIL hwm_clear: got %0d want 3", rd_numdata_max);
    end
    rd_req = 1; r_auto_restart = 0; rd_numdata = 4'd8;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (rd_state !== 2'd2) begin
      failures++;
      $display("FAIL hwm_read: state %0d want 2", rd_state);
    end
    rd_srst = 1;
    tick();
    checks++;
    if (act !== 12'b0_1_1_0_0_0_0000_00) begin
      failures++;
      $display("FAIL reset_in_read: got %b want %b", act, 12'b011000000000);
    end
    rd_srst = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rd_srst           = ($urandom_range(0, 59) == 0);
      rd_numdata        = 4'($urandom);
      rd_req            = ($urandom_range(0, 3) != 0);
      r_fifo_power_mode = 3'($urandom);
      r_double_read     = ($urandom_range(0, 3) == 0);
      r_stop_read       = 1'($urandom);
      r_empty_thresh    = 4'($urandom_range(0, 3));
      r_pempty_thresh   = 4'($urandom);
      r_pfull_thresh    = 4'($urandom);
      r_start_level     = 4'($urandom);
      r_auto_restart    = 1'($urandom);
      status_clr        = ($urandom_range(0, 9) == 0);
      tick();
      checks++;
      if (act !== exp_vec()) begin
        failures++;
        $display("FAIL random[%0d]: got %b want %b", i, act, exp_vec());
      end
    end
    rd_srst = 0;
  endtask

  initial begin
    rd_srst = 1; rd_numdata = 0; rd_req = 0;
    r_fifo_power_mode = 3'b110; r_double_read = 0; r_stop_read = 0;
    r_empty_thresh = 0; r_pempty_thresh = 4'd2; r_pfull_thresh = 4'd12;
    r_start_level = 4'd4; r_auto_restart = 0; status_clr = 0;
    m_state = 0; m_q = 0; m_max = 0;
    m_empty = 1; m_pempty = 1; m_pfull = 0; m_uf = 0; m_sticky = 0;
    test_reset();
    test_fill();
    test_pfull_clamp();
    test_underflow_restart();
    test_underflow_stay();
    test_double_read();
    test_hwm_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hdpldadapt_rx_datapath_fifo_rd_ctl.md
Name: hdpldadapt_rx_datapath_fifo_rd_ctl

Overview:
- Read-domain flag and read-enable controller for the RX datapath FIFO.
- Consumes the read-side occupancy count (rd_numdata) from the RX FIFO pointer block.
- Produces rd_en and rd_empty back into that pointer block, plus the partial flags, underflow status and an occupancy high-water mark for the RX channel status path.
- A start-up fill FSM holds reads off until the FIFO reaches a programmed level.

Parameters:
- AWIDTH, 4, FIFO address width; width of occupancy and threshold buses.
- DEPTH, 16, full FIFO depth (entries).
- PS_DEPTH, 8, power-save FIFO depth (entries).

Ports:
- rd_clk  in  1  read-domain clock
- rd_srst  in  1  reset; synchronous, active-high
- rd_numdata  in  AWIDTH  occupancy from the pointer block (write pointer synced minus next read pointer)
- rd_req  in  1  downstream request to pop data
- r_fifo_power_mode  in  3  depth select: bit1=0 selects PS_DEPTH; else bit2=0 selects 2*PS_DEPTH; else DEPTH
- r_double_read  in  1  each read consumes 2 entries
- r_stop_read  in  1  1 = suppress rd_en while rd_empty
- r_empty_thresh  in  AWIDTH  empty asserted when occupancy <= value
- r_pempty_thresh  in  AWIDTH  partial-empty threshold (<=)
- r_pfull_thresh  in  AWIDTH  partial-full threshold (>=)
- r_start_level  in  AWIDTH  occupancy required to leave FILL
- r_auto_restart  in  1  on underflow, return to FILL
- status_clr  in  1  single-cycle pulse; clears sticky status and the high-water mark
- rd_en  out  1  read enable to the pointer block
- rd_empty  out  1  registered empty flag
- rd_pempty  out  1  registered partial-empty flag
- rd_pfull  out  1  registered partial-full flag
- rd_underflow  out  1  single-cycle underflow pulse
- rd_underflow_sticky  out  1  sticky underflow status
- rd_numdata_max  out  AWIDTH  high-water mark of occupancy
- rd_state  out  2  FSM state: 0 = IDLE, 1 = FILL, 2 = READ

Behaviour:
- Reset (rd_srst=1 at a rd_clk edge):
  - state=IDLE, numdata_q=0, rd_empty=1, rd_pempty=1.
  - rd_pfull, rd_underflow, rd_underflow_sticky and rd_numdata_max all 0.
  - rd_en=0.
  - Reset mid-operation aborts any state the same edge.
- Effective depth:
  - E = PS_DEPTH, 2*PS_DEPTH or DEPTH per r_fifo_power_mode.
  - Every threshold is clamped to min(thresh, E-1) before comparison.
  - Comparisons are unsigned, AWIDTH bits.
- numdata_q: rd_numdata registered every cycle. All flags are derived from numdata_q and registered, so a flag updates 2 cycles after its rd_numdata value is presented.
- Flags:
  - rd_empty = (numdata_q <= empty_eff), or (r_double_read and numdata_q < 2).
  - rd_pempty = numdata_q <= pempty_eff.
  - rd_pfull = numdata_q >= pfull_eff.
- FSM:
  - IDLE -> FILL unconditionally after one cycle.
  - FILL -> READ when numdata_q >= start_eff.
  - READ -> FILL on underflow when r_auto_restart=1; otherwise stays in READ.
  - start_eff=0 means FILL exits on its first cycle.
- rd_en (combinational from registered state only):
  - rd_en = (state==READ) & rd_req & ~(r_stop_read & rd_empty).
  - No combinational path from rd_numdata to rd_en; this breaks the loop through the pointer block.
  - rd_en=0 in IDLE and FILL regardless of rd_req.
- Underflow:
  - rd_underflow=1 for one cycle, registered, the cycle after state==READ & rd_req & rd_empty.
  - Fires even when r_stop_read gates rd_en.
  - rd_underflow_sticky is set by underflow and cleared by status_clr. Set wins when both occur in the same cycle.
- High-water mark:
  - rd_numdata_max <= max(rd_numdata_max, numdata_q) every cycle.
  - status_clr loads numdata_q instead of that max.
- Double read: the thresholds still count single entries; the pointer block itself advances by 2 per rd_en.
- A change to r_fifo_power_mode at run time takes effect on the next flag update; no state change is forced.

Test Plan:
1. Reset, then rd_numdata ramps 0..6, r_start_level=4, rd_req=1 -> rd_state goes 0->1->2 at the 2nd edge after rd_numdata=4; rd_en=0 until READ.
2. r_fifo_power_mode=3'b000, r_pfull_thresh=12, rd_numdata=7 -> pfull_eff clamps to 7 and rd_pfull=1; the same input with mode 3'b110 (E=16) -> rd_pfull=0.
3. READ with rd_numdata=0, r_empty_thresh=0, rd_req=1, r_stop_read=1 -> rd_empty=1, rd_en=0, one rd_underflow pulse; with r_auto_restart=1, rd_state returns to 1.
4. Same as 3 with r_stop_read=0, r_auto_restart=0 -> rd_en=1 throughout, underflow pulse fires, rd_state stays 2, sticky=1 until status_clr.
5. r_double_read=1, r_empty_thresh=0, rd_numdata=1 -> rd_empty=1; rd_numdata=2 -> rd_empty=0.
6. rd_numdata peaks at 9 and then drops to 3; pulse status_clr -> rd_numdata_max reads 9 before the pulse and 3 after it. Asserting rd_srst while in READ -> all outputs at reset values after the next edge.
